// File: rtl/reg_dest_queue_pkg.sv
// Shared constants for register-destination selection and queueing.
// Select codes and the default fixed indices used by the datapath.
package reg_dest_queue_pkg;

    localparam logic [2:0] SEL_RT = 3'd0;
    localparam logic [2:0] SEL_RS = 3'd1;
    localparam logic [2:0] SEL_SP = 3'd2;
    localparam logic [2:0] SEL_RA = 3'd3;
    localparam logic [2:0] SEL_RD = 3'd4;

    localparam int unsigned SP_IDX_DEFAULT = 29;
    localparam int unsigned RA_IDX_DEFAULT = 31;

endpackage

// File: rtl/reg_dest_sel.sv
// Combinational mapping from the 3-bit RegDest code to a register index.
// Reserved codes yield index 0 and raise the reserved flag.
module reg_dest_sel
    import reg_dest_queue_pkg::*;
#(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned SP_IDX = SP_IDX_DEFAULT,
    parameter int unsigned RA_IDX = RA_IDX_DEFAULT
) (
    input  logic [2:0]       sel,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] idx,
    output logic             reserved
);

    always_comb begin
        idx      = '0;
        reserved = 1'b0;
        case (sel)
            SEL_RT:  idx = rt;
            SEL_RS:  idx = rs;
            SEL_SP:  idx = REG_W'(SP_IDX);
            SEL_RA:  idx = REG_W'(RA_IDX);
            SEL_RD:  idx = rd;
            default: reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_dest_queue.sv
// In-order queue of pending register-write destinations with RAW-hazard
// flags against two source indices.
module reg_dest_queue
    import reg_dest_queue_pkg::*;
#(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SP_IDX = SP_IDX_DEFAULT,
    parameter int unsigned RA_IDX = RA_IDX_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   RegDest,
    input  logic [REG_W-1:0]             rt,
    input  logic [REG_W-1:0]             rs,
    input  logic [REG_W-1:0]             rd,
    input  logic                         push,
    input  logic                         pop,
    input  logic [REG_W-1:0]             src_a,
    input  logic [REG_W-1:0]             src_b,
    output logic [OUT_W-1:0]             dest_out,
    output logic                         dest_valid,
    output logic                         hazard_a,
    output logic                         hazard_b,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         bad_sel
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [REG_W-1:0] sel_idx;
    logic             sel_reserved;

    logic [REG_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             overflow_q, underflow_q, bad_sel_q;

    logic is_full, is_empty, push_ok, pop_ok;

    reg_dest_sel #(
        .REG_W  (REG_W),
        .SP_IDX (SP_IDX),
        .RA_IDX (RA_IDX)
    ) u_sel (
        .sel      (RegDest),
        .rt       (rt),
        .rs       (rs),
        .rd       (rd),
        .idx      (sel_idx),
        .reserved (sel_reserved)
    );

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign pop_ok   = pop && !is_empty;
    // A full queue still accepts a push when the oldest entry leaves this cycle.
    assign push_ok  = push && (!is_full || pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            bad_sel_q   <= 1'b0;
        end else begin
            overflow_q  <= push && !push_ok;
            underflow_q <= pop && is_empty;
            bad_sel_q   <= push && sel_reserved;

            // Clear before set: when full, push and pop target the same slot.
            if (pop_ok) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push_ok) begin
                mem_q[wr_ptr_q]   <= sel_idx;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end

            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && mem_q[i] == src_a && src_a != '0) hazard_a = 1'b1;
            if (valid_q[i] && mem_q[i] == src_b && src_b != '0) hazard_b = 1'b1;
        end
    end

    always_comb begin
        dest_out = '0;
        if (!is_empty) dest_out = {{(OUT_W - REG_W){1'b0}}, mem_q[rd_ptr_q]};
    end

    assign dest_valid = !is_empty;
    assign count      = count_q;
    assign full       = is_full;
    assign empty      = is_empty;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign bad_sel    = bad_sel_q;

endmodule

// File: tb/tb_reg_dest_queue.sv
// Self-checking bench for reg_dest_queue: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_reg_dest_queue;

    localparam int DEPTH = 4;
    localparam int REG_W = 5;
    localparam int OUT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       RegDest;
    logic [REG_W-1:0] rt, rs, rd, src_a, src_b;
    logic             push, pop;
    logic [OUT_W-1:0] dest_out;
    logic             dest_valid, hazard_a, hazard_b, full, empty;
    logic             overflow, underflow, bad_sel;
    logic [2:0]       count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int q[$];
    bit m_over, m_under, m_bad;

    always #5 clk = ~clk;

    reg_dest_queue #(
        .REG_W  (REG_W),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH),
        .SP_IDX (29),
        .RA_IDX (31)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RegDest    (RegDest),
        .rt         (rt),
        .rs         (rs),
        .rd         (rd),
        .push       (push),
        .pop        (pop),
        .src_a      (src_a),
        .src_b      (src_b),
        .dest_out   (dest_out),
        .dest_valid (dest_valid),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow),
        .bad_sel    (bad_sel)
    );

    function automatic int model_sel(input int code);
        case (code)
            0: return int'(rt);
            1: return int'(rs);
            2: return 29;
            3: return 31;
            4: return int'(rd);
            default: return 0;
        endcase
    endfunction

    function automatic bit model_hazard(input int src);
        if (src == 0) return 1'b0;
        foreach (q[i]) if (q[i] == src) return 1'b1;
        return 1'b0;
    endfunction

    // Apply the current inputs for one clock edge and advance the model alongside.
    task automatic cycle(input bit p, input bit o, input int code);
        bit do_pop, do_push;
        int idx;
        push = p; pop = o; RegDest = 3'(code);
        idx     = model_sel(code);
        do_pop  = o && q.size() > 0;
        do_push = p && (q.size() < DEPTH || do_pop);
        m_over  = p && !do_push;
        m_under = o && q.size() == 0;
        m_bad   = p && code > 4;
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(idx);
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; push = 0; pop = 0; RegDest = 0;
        rt = 0; rs = 0; rd = 0; src_a = 0; src_b = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || dest_valid !== 1'b0
            || dest_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b valid=%b dest=%0d, want 0 1 0 0 0",
                     count, empty, full, dest_valid, dest_out);
        end
        checks++;
        if (overflow !== 0 || underflow !== 0 || bad_sel !== 0) begin
            failures++;
            $display("FAIL reset_pulses: ovf=%b unf=%b bad=%b, want 0 0 0",
                     overflow, underflow, bad_sel);
        end
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_single_push;
        rd = 5'd8;
        cycle(1, 0, 4);
        src_a = 5'd8; src_b = 5'd9;
        #1;
        checks++;
        if (dest_out !== 32'd8 || count !== 3'd1 || dest_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_push: dest=%0d count=%0d valid=%b, want 8 1 1",
                     dest_out, count, dest_valid);
        end
        checks++;
        if (hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
            failures++;
            $display("FAIL single_hazard: a=%b b=%b, want 1 0", hazard_a, hazard_b);
        end
        cycle(0, 1, 0);
        checks++;
        if (empty !== 1'b1 || hazard_a !== 1'b0) begin
            failures++;
            $display("FAIL single_pop: empty=%b hazard_a=%b, want 1 0", empty, hazard_a);
        end
        src_a = 0; src_b = 0;
    endtask

    task automatic test_fill_overflow;
        int exp_seq[4] = '{3, 29, 31, 7};
        rt = 5'd3; cycle(1, 0, 0);
        cycle(1, 0, 2);
        cycle(1, 0, 3);
        rs = 5'd7; cycle(1, 0, 1);
        checks++;
        if (full !== 1'b1 || count !== 3'd4) begin
            failures++;
            $display("FAIL fill: full=%b count=%0d, want 1 4", full, count);
        end
        rd = 5'd20; cycle(1, 0, 4);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            failures++;
            $display("FAIL overflow: ovf=%b count=%0d, want 1 4", overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dest_out !== 32'(exp_seq[i])) begin
                failures++;
                $display("FAIL drain[%0d]: dest=%0d, want %0d", i, dest_out, exp_seq[i]);
            end
            cycle(0, 1, 0);
            if (i == 0) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL overflow_pulse_len: ovf=%b, want 0", overflow);
                end
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            failures++;
            $display("FAIL drained: empty=%b count=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_underflow;
        cycle(0, 1, 0);
        checks++;
        if (underflow !== 1'b1 || count !== 3'd0) begin
            failures++;
            $display("FAIL underflow: unf=%b count=%0d, want 1 0", underflow, count);
        end
        rt = 5'd5; cycle(1, 1, 0);
        checks++;
        if (underflow !== 1'b1 || count !== 3'd1 || dest_out !== 32'd5) begin
            failures++;
            $display("FAIL underflow_push: unf=%b count=%0d dest=%0d, want 1 1 5",
                     underflow, count, dest_out);
        end
        cycle(0, 1, 0);
        checks++;
        if (underflow !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL underflow_clear: unf=%b empty=%b, want 0 1", underflow, empty);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < DEPTH; i++) begin
            rd = 5'(10 + i); cycle(1, 0, 4);
        end
        for (int i = 0; i < 2 * DEPTH; i++) begin
            rd = 5'(12 + i); cycle(1, 1, 4);
            checks++;
            if (count !== 3'd4 || dest_out !== 32'(q[0]) || overflow !== 1'b0) begin
                failures++;
                $display("FAIL wrap[%0d]: count=%0d dest=%0d ovf=%b, want 4 %0d 0",
                         i, count, dest_out, overflow, q[0]);
            end
        end
        while (q.size() > 0) begin
            checks++;
            if (dest_out !== 32'(q[0])) begin
                failures++;
                $display("FAIL wrap_drain: dest=%0d, want %0d", dest_out, q[0]);
            end
            cycle(0, 1, 0);
        end
    endtask

    task automatic test_bad_sel;
        rt = 5'd9; rs = 5'd9; rd = 5'd9;
        cycle(1, 0, 6);
        src_a = 0;
        #1;
        checks++;
        if (bad_sel !== 1'b1 || count !== 3'd1 || dest_out !== 32'd0 || hazard_a !== 1'b0) begin
            failures++;
            $display("FAIL bad_sel: bad=%b count=%0d dest=%0d hz=%b, want 1 1 0 0",
                     bad_sel, count, dest_out, hazard_a);
        end
        cycle(0, 0, 0);
        checks++;
        if (bad_sel !== 1'b0) begin
            failures++;
            $display("FAIL bad_sel_pulse_len: bad=%b, want 0", bad_sel);
        end
        cycle(0, 1, 0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            rt = 5'($urandom); rs = 5'($urandom); rd = 5'($urandom);
            src_a = 5'($urandom_range(0, 7)); src_b = 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 7));
            checks++;
            if (count !== 3'(q.size())
                || dest_out !== (q.size() > 0 ? 32'(q[0]) : 32'd0)
                || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)
                || hazard_a !== model_hazard(int'(src_a))
                || hazard_b !== model_hazard(int'(src_b))
                || overflow !== m_over || underflow !== m_under || bad_sel !== m_bad) begin
                failures++;
                $display("FAIL random[%0d]: cnt=%0d dst=%0d hz=%b%b pulses=%b%b%b, want cnt=%0d dst=%0d hz=%b%b pulses=%b%b%b",
                         n, count, dest_out, hazard_a, hazard_b, overflow, underflow, bad_sel,
                         q.size(), (q.size() > 0 ? q[0] : 0), model_hazard(int'(src_a)),
                         model_hazard(int'(src_b)), m_over, m_under, m_bad);
            end
        end
    endtask

    task automatic test_async_reset;
        while (q.size() > 0) cycle(0, 1, 0);
        rd = 5'd4; cycle(1, 0, 4);
        rd = 5'd6; cycle(1, 0, 4);
        rd = 5'd7; cycle(1, 0, 4);
        src_a = 5'd4; src_b = 5'd7;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== 3'd0 || dest_valid !== 1'b0 || dest_out !== 32'd0
            || hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: empty=%b count=%0d valid=%b dest=%0d hz=%b%b, want 1 0 0 0 00",
                     empty, count, dest_valid, dest_out, hazard_a, hazard_b);
        end
        q.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        rt = 5'd2; cycle(1, 0, 0);
        checks++;
        if (count !== 3'd1 || dest_out !== 32'd2) begin
            failures++;
            $display("FAIL post_reset_push: count=%0d dest=%0d, want 1 2", count, dest_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_underflow();
        test_wrap();
        test_bad_sel();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
